// File: rtl/reg_pkg.sv
// Shared definitions for the register-bank sequencer.
//   state_t      : sequencer FSM states
//   NUM_REGS_DEF : default number of registers in the bank
//   IDX_W_DEF    : default register index width
//   CNT_W        : width of the ALU wait counter (holds TIMEOUT up to 255)
//   onehot()     : index -> one-hot vector, ONEHOT_W bits wide
package reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int NUM_REGS_DEF = 6;
    localparam int IDX_W_DEF    = 3;
    localparam int ONEHOT_W     = 32;
    localparam int CNT_W        = 8;

    // Indices beyond ONEHOT_W shift the single bit out, giving all zeros.
    function automatic logic [ONEHOT_W-1:0] onehot(input int idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Index to one-hot enable decoder.
//   idx_i    : register index
//   en_i     : decode enable; 0 forces an all-zero output
//   onehot_o : NUM_REGS-wide one-hot vector, zero when disabled or idx_i >= NUM_REGS
module reg_onehot_dec
    import reg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic [IDX_W-1:0]    idx_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i && (int'(idx_i) < NUM_REGS)) begin
            onehot_o = NUM_REGS'(onehot(int'(idx_i)));
        end
    end

endmodule

// File: rtl/reg_port_sequencer.sv
// Register-bank sequencer: takes one (src1, src2, dst) command, drives the one-hot
// read enables of both bus ports, waits a bounded time for the ALU, then pulses one
// save enable. All outputs come straight from registers.
//   clk, rst                : clock (rising edge), asynchronous active-low reset
//   cmd_valid / cmd_ready   : command handshake; ready only while IDLE
//   cmd_src1/src2/rd2       : source registers for bus 1 / bus 2 (bus 2 if rd2)
//   cmd_dst/cmd_wr          : destination register, write-back request
//   alu_done                : ALU result valid (only looked at in WAIT)
//   load1_en/load2_en       : one-hot/zero bus-port read enables
//   save_en                 : one-hot/zero save enable, high for the WRITE cycle
//   busy, done, err         : not-idle flag, completion pulse, error pulse
module reg_port_sequencer
    import reg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IDX_W-1:0]    cmd_src1,
    input  logic [IDX_W-1:0]    cmd_src2,
    input  logic                cmd_rd2,
    input  logic [IDX_W-1:0]    cmd_dst,
    input  logic                cmd_wr,
    input  logic                alu_done,
    output logic [NUM_REGS-1:0] load1_en,
    output logic [NUM_REGS-1:0] load2_en,
    output logic [NUM_REGS-1:0] save_en,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    dst_q, dst_d;
    logic                wr_q, wr_d;
    logic [NUM_REGS-1:0] load1_q, load1_d;
    logic [NUM_REGS-1:0] load2_q, load2_d;
    logic [NUM_REGS-1:0] save_q, save_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                idx_bad;
    logic                timed_out;
    logic [NUM_REGS-1:0] dec_src1, dec_src2, dec_dst;

    assign accept    = cmd_valid && (state_q == IDLE);
    // Only indices that the command actually uses are range-checked.
    assign idx_bad   = (int'(cmd_src1) >= NUM_REGS)
                    || (cmd_rd2 && (int'(cmd_src2) >= NUM_REGS))
                    || (cmd_wr  && (int'(cmd_dst)  >= NUM_REGS));
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

    reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_src1 (
        .idx_i(cmd_src1), .en_i(1'b1),    .onehot_o(dec_src1)
    );
    reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_src2 (
        .idx_i(cmd_src2), .en_i(cmd_rd2), .onehot_o(dec_src2)
    );
    reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_dst (
        .idx_i(dst_q),    .en_i(wr_q),    .onehot_o(dec_dst)
    );

    // State and control registers; reset drops every enable at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            load1_q <= '0;
            load2_q <= '0;
            save_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            load1_q <= load1_d;
            load2_q <= load2_d;
            save_q  <= save_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Destination index is plain data: only meaningful after an accepted command.
    always_ff @(posedge clk) begin
        dst_q <= dst_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !idx_bad) state_d = READ;
            READ:    state_d = WAIT;
            WAIT: begin
                // alu_done takes priority over a coinciding timeout.
                if (alu_done)       state_d = wr_q ? WRITE : IDLE;
                else if (timed_out) state_d = IDLE;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        wr_d    = wr_q;
        load1_d = load1_q;
        load2_d = load2_q;
        save_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (idx_bad) begin
                        err_d = 1'b1;
                    end else begin
                        load1_d = dec_src1;
                        load2_d = dec_src2;
                        dst_d   = cmd_dst;
                        wr_d    = cmd_wr;
                    end
                end
            end
            // Counter holds the 1-based index of the current WAIT cycle.
            READ: cnt_d = CNT_W'(1);
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (alu_done && wr_q) begin
                    save_d = dec_dst;
                    done_d = 1'b1;
                end else if (alu_done || timed_out) begin
                    done_d  = alu_done;
                    err_d   = !alu_done;
                    cnt_d   = '0;
                    load1_d = '0;
                    load2_d = '0;
                end
            end
            WRITE: begin
                cnt_d   = '0;
                load1_d = '0;
                load2_d = '0;
            end
            default: begin
                cnt_d   = '0;
                load1_d = '0;
                load2_d = '0;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign load1_en  = load1_q;
    assign load2_en  = load2_q;
    assign save_en   = save_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Directed bench for reg_port_sequencer (NUM_REGS=6, IDX_W=3, TIMEOUT=15).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_reg_port_sequencer;

    localparam int NR = 6;
    localparam int IW = 3;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IW-1:0] cmd_src1 = '0;
    logic [IW-1:0] cmd_src2 = '0;
    logic          cmd_rd2 = 1'b0;
    logic [IW-1:0] cmd_dst = '0;
    logic          cmd_wr = 1'b0;
    logic          alu_done = 1'b0;
    logic [NR-1:0] load1_en, load2_en, save_en;
    logic          busy, done, err;

    int   checks = 0;
    int   errors = 0;
    logic onehot_bad = 1'b0;

    reg_port_sequencer #(.NUM_REGS(NR), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_rd2(cmd_rd2),
        .cmd_dst(cmd_dst), .cmd_wr(cmd_wr), .alu_done(alu_done),
        .load1_en(load1_en), .load2_en(load2_en), .save_en(save_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(load1_en) > 1 || $countones(load2_en) > 1 || $countones(save_en) > 1)
            onehot_bad = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chkv(input string tag, input logic [NR-1:0] obs, input logic [NR-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic set_cmd(input logic [IW-1:0] s1, input logic [IW-1:0] s2, input logic rd2,
                           input logic [IW-1:0] d, input logic wr);
        cmd_src1 = s1; cmd_src2 = s2; cmd_rd2 = rd2; cmd_dst = d; cmd_wr = wr;
    endtask

    // Presents one command for one edge; returns in the cycle after the accept edge.
    task automatic send(input logic [IW-1:0] s1, input logic [IW-1:0] s2, input logic rd2,
                        input logic [IW-1:0] d, input logic wr);
        set_cmd(s1, s2, rd2, d, wr);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk1("rst_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chkv("rst_load1", load1_en, 6'b000000);
        chkv("rst_save", save_en, 6'b000000);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b1;
        tick();

        // Full write command, alu_done on the first WAIT cycle
        send(3'd1, 3'd3, 1'b1, 3'd4, 1'b1);
        chkv("t2_c1_load1", load1_en, 6'b000010);
        chkv("t2_c1_load2", load2_en, 6'b001000);
        chk1("t2_c1_ready", cmd_ready, 1'b0);
        chk1("t2_c1_busy", busy, 1'b1);
        tick();
        chkv("t2_c2_load1", load1_en, 6'b000010);
        chkv("t2_c2_save", save_en, 6'b000000);
        chk1("t2_c2_done", done, 1'b0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chkv("t2_c3_save", save_en, 6'b010000);
        chk1("t2_c3_done", done, 1'b1);
        chkv("t2_c3_load2", load2_en, 6'b001000);
        tick();
        chk1("t2_c4_ready", cmd_ready, 1'b1);
        chkv("t2_c4_save", save_en, 6'b000000);
        chkv("t2_c4_load1", load1_en, 6'b000000);
        chk1("t2_c4_done", done, 1'b0);

        // Read-only command, single port, alu_done after two WAIT cycles
        send(3'd0, 3'd5, 1'b0, 3'd2, 1'b0);
        chkv("t3_c1_load1", load1_en, 6'b000001);
        chkv("t3_c1_load2", load2_en, 6'b000000);
        tick(); tick();
        chkv("t3_w2_load2", load2_en, 6'b000000);
        chk1("t3_w2_busy", busy, 1'b1);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk1("t3_done", done, 1'b1);
        chkv("t3_save", save_en, 6'b000000);
        chk1("t3_idle", busy, 1'b0);
        tick();
        chk1("t3_done_pulse", done, 1'b0);

        // Timeout with src1 == src2
        send(3'd2, 3'd2, 1'b1, 3'd3, 1'b1);
        chkv("t4_same_load1", load1_en, 6'b000100);
        chkv("t4_same_load2", load2_en, 6'b000100);
        for (int i = 0; i < TO; i++) tick();
        chk1("t4_last_wait_busy", busy, 1'b1);
        chk1("t4_last_wait_err", err, 1'b0);
        tick();
        chk1("t4_err", err, 1'b1);
        chk1("t4_busy", busy, 1'b0);
        chkv("t4_save", save_en, 6'b000000);
        chkv("t4_load1", load1_en, 6'b000000);
        tick();
        chk1("t4_err_pulse", err, 1'b0);

        // alu_done coinciding with the timeout cycle
        send(3'd2, 3'd2, 1'b1, 3'd3, 1'b1);
        for (int i = 0; i < TO; i++) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk1("t4b_err", err, 1'b0);
        chk1("t4b_done", done, 1'b1);
        chkv("t4b_save", save_en, 6'b001000);
        tick();
        chk1("t4b_idle", cmd_ready, 1'b1);

        // alu_done while idle is ignored
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk1("idle_alu_busy", busy, 1'b0);
        chk1("idle_alu_done", done, 1'b0);

        // Bad destination index
        send(3'd1, 3'd0, 1'b0, 3'd7, 1'b1);
        chk1("t5_err", err, 1'b1);
        chk1("t5_busy", busy, 1'b0);
        chkv("t5_load1", load1_en, 6'b000000);
        tick();
        chk1("t5_err_pulse", err, 1'b0);
        chk1("t5_ready", cmd_ready, 1'b1);

        // Out-of-range src2 is not checked when port 2 is unused
        send(3'd1, 3'd7, 1'b0, 3'd2, 1'b0);
        chk1("t5b_busy", busy, 1'b1);
        chk1("t5b_err", err, 1'b0);
        chkv("t5b_load2", load2_en, 6'b000000);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk1("t5b_done", done, 1'b1);

        // Back-to-back with cmd_valid held high
        set_cmd(3'd3, 3'd0, 1'b0, 3'd5, 1'b1);
        cmd_valid = 1'b1;
        tick();
        set_cmd(3'd4, 3'd0, 1'b1, 3'd0, 1'b0);
        chkv("t6_a_load1", load1_en, 6'b001000);
        tick();
        chkv("t6_a_hold", load1_en, 6'b001000);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chkv("t6_a_save", save_en, 6'b100000);
        chkv("t6_a_load1_w", load1_en, 6'b001000);
        tick();
        chk1("t6_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chkv("t6_b_load1", load1_en, 6'b010000);
        chkv("t6_b_load2", load2_en, 6'b000001);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk1("t6_b_done", done, 1'b1);
        chkv("t6_b_save", save_en, 6'b000000);

        // Reset in the middle of WAIT
        send(3'd2, 3'd0, 1'b0, 3'd1, 1'b1);
        tick();
        chkv("t1_pre_load1", load1_en, 6'b000100);
        rst = 1'b0;
        #1;
        chkv("t1_async_load1", load1_en, 6'b000000);
        chk1("t1_async_busy", busy, 1'b0);
        chk1("t1_async_ready", cmd_ready, 1'b1);
        #3;
        rst = 1'b1;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chkv("t1_post_save", save_en, 6'b000000);
        chk1("t1_post_done", done, 1'b0);
        chk1("t1_post_ready", cmd_ready, 1'b1);
        chk1("t1_post_busy", busy, 1'b0);

        chk1("onehot_all_cycles", onehot_bad, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
